// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Each requester gets a one-entry registered response buffer.

module alu_arbiter_rsp_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            grant,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            rsp_ready,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_zero
);
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else if (grant) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

module alu_arbiter #(
  parameter int XLEN      = 32,
  parameter int PRIO_INIT = 0,
  parameter int STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [XLEN-1:0]    req0_op1,
  input  logic [XLEN-1:0]    req0_op2,
  input  logic [3:0]         req0_alu_ctrl,
  input  logic               req0_branch,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [XLEN-1:0]    rsp0_result,
  output logic               rsp0_zero,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [XLEN-1:0]    req1_op1,
  input  logic [XLEN-1:0]    req1_op2,
  input  logic [3:0]         req1_alu_ctrl,
  input  logic               req1_branch,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [XLEN-1:0]    rsp1_result,
  output logic               rsp1_zero,
  output logic [XLEN-1:0]    alu_op1,
  output logic [XLEN-1:0]    alu_op2,
  output logic [3:0]         alu_ctrl,
  output logic               alu_branch,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               alu_zero,
  output logic [STALL_W-1:0] stall_cnt
);
  localparam int N = 2;

  logic [N-1:0]           req_valid, req_branch, rsp_valid, rsp_ready, rsp_zero;
  logic [N-1:0][XLEN-1:0] req_op1, req_op2, rsp_result;
  logic [N-1:0][3:0]      req_ctrl;
  logic [N-1:0]           elig, grant;
  logic                   last;
  logic                   stall;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_branch = {req1_branch, req0_branch};
  assign req_op1    = {req1_op1, req0_op1};
  assign req_op2    = {req1_op2, req0_op2};
  assign req_ctrl   = {req1_alu_ctrl, req0_alu_ctrl};
  assign rsp_ready  = {rsp1_ready, rsp0_ready};

  // A full buffer that drains this cycle can accept a refill in the same cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    grant = '0;
    if (!rst) begin
      if (&elig) grant[~last] = 1'b1;
      else       grant = elig;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    alu_op1    = '0;
    alu_op2    = '0;
    alu_ctrl   = '0;
    alu_branch = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        alu_op1    = req_op1[i];
        alu_op2    = req_op2[i];
        alu_ctrl   = req_ctrl[i];
        alu_branch = req_branch[i];
      end
    end
  end

  // Pointer resets to the non-preferred index so PRIO_INIT wins the first tie.
  always_ff @(posedge clk) begin
    if (rst)        last <= (PRIO_INIT == 0);
    else if (|grant) last <= grant[1];
  end

  assign stall = |(elig & ~grant);

  always_ff @(posedge clk) begin
    if (rst)                           stall_cnt <= '0;
    else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  for (genvar g = 0; g < N; g++) begin : g_rsp
    alu_arbiter_rsp_buf #(.XLEN(XLEN)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .grant      (grant[g]),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .rsp_ready  (rsp_ready[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_result (rsp_result[g]),
      .rsp_zero   (rsp_zero[g])
    );
  end

  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_zero   = rsp_zero[0];
  assign rsp1_zero   = rsp_zero[1];
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational integer ALU (32-bit operands, 4-bit alu_ctrl, branch compare flag, result/zero outputs) between two requesters: requester 0 is the integer pipeline, requester 1 is the address/branch-compare unit.
- Grants at most one requester per cycle using round-robin arbitration.
- Drives the ALU ports from the granted requester and registers each result into a one-entry response buffer per requester, with valid/ready handshakes on both sides.

Parameters:
XLEN, 32, operand/result width (must match the ALU)
PRIO_INIT, 0, requester that wins the first tie after reset (0 or 1)
STALL_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op1  input  XLEN  operand 1
req0_op2  input  XLEN  operand 2
req0_alu_ctrl  input  4  ALU operation code
req0_branch  input  1  compare mode (zero output meaningful)
rsp0_valid  output  1  requester 0 result held
rsp0_ready  input  1  requester 0 consumes result
rsp0_result  output  XLEN  registered ALU result
rsp0_zero  output  1  registered ALU zero/branch-taken flag
req1_* / rsp1_*  same set and widths as requester 0
alu_op1  output  XLEN  to ALU op1
alu_op2  output  XLEN  to ALU op2
alu_ctrl  output  4  to ALU alu_ctrl
alu_branch  output  1  to ALU branch
alu_result  input  XLEN  from ALU result (combinational, same cycle)
alu_zero  input  1  from ALU zero (combinational, same cycle)
stall_cnt  output  STALL_W  cycles in which an eligible requester lost arbitration, saturating

Behaviour:
- Clocking and reset: single clock domain. Synchronous active-high reset.
- Reset values: rsp*_valid=0, rsp*_result=0, rsp*_zero=0, stall_cnt=0. The last-served pointer resets to the index that is not PRIO_INIT.
- Eligibility: elig[i] = req_i_valid & (~rsp_i_valid | rsp_i_ready). A requester whose buffer is full and not being drained this cycle is not eligible. Same-cycle drain-and-refill is allowed.
- Arbitration (combinational, once per cycle):
  - Exactly one eligible requester wins.
  - Both eligible: the requester not equal to the last-served pointer wins.
  - Neither eligible: no grant.
- req_i_ready = grant[i]. Handshake completes when req_i_valid & req_i_ready. req_i_ready never asserts without req_i_valid.
- ALU drive:
  - With a grant, alu_op1/op2/ctrl/branch are the winner's inputs, passed combinationally.
  - With no grant, all ALU ports are driven to 0 (ADD of 0,0, branch=0).
- Capture:
  - On the grant edge: rsp_w_result <= alu_result, rsp_w_zero <= alu_zero, rsp_w_valid <= 1. Latency is 1 cycle from accept to rsp_valid.
  - The pointer updates to the winner index on every grant.
- Drain: rsp_i_valid & rsp_i_ready with no new grant to i clears rsp_i_valid. Result/zero hold their last values; they are don't-care once valid is 0.
- Hold: an un-consumed response holds result, zero and valid stable until rsp_i_ready.
- The zero flag is captured as-is. The ALU forces it to 0 when branch=0, and this block performs no further decode of alu_ctrl.
- stall_cnt: increments by 1 in any cycle where some elig[i]=1 and grant[i]=0. It saturates at all-ones and is cleared only by reset.
- Fairness: with both requesters continuously eligible, grants alternate 0,1,0,1… No requester waits more than one grant.
- Reset mid-operation: any held response is discarded (valid=0), the pointer returns to its reset value, and no grant is issued in a cycle where rst=1 (req*_ready=0).
- Request operands must stay stable while req_valid=1 and ready=0. This block does not register requests.

Test Plan:
- Single requester ADD: req0 op1=5, op2=7, ctrl=0000 → req0_ready=1 same cycle, alu_op1=5; next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
- Branch compare on req1: op1=op2=0x10, ctrl=0000, branch=1 → rsp1_zero=1. With op2=0x11 → rsp1_zero=0.
- Tie after reset (PRIO_INIT=0), both valid with ready responses every cycle → grants 0,1,0,1 for 4 cycles; stall_cnt=4.
- Backpressure: rsp0_valid=1, rsp0_ready=0, req0_valid=1 → req0_ready=0 and rsp0_result holds for 5 cycles. Raising rsp0_ready → grant that cycle, new result next cycle.
- Idle: no requests → alu_op1=alu_op2=0, alu_ctrl=0, alu_branch=0; stall_cnt unchanged.
- Reset with rsp1_valid=1 → next cycle rsp1_valid=0, stall_cnt=0, and the first tie goes to requester 0.
